// File: rtl/bf_io_pkg.sv
// Shared types and constants for the buffered BFCPU console I/O bridge.
package bf_io_pkg;

    localparam int unsigned STAT_W  = 32;
    localparam logic        EOF_BIT = 1'b1;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_DATA,
        RD_EOF,
        RD_WAIT
    } rd_act_e;

    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bf_io_bridge_if.sv
// CPU toggle pins and byte-stream handshakes of the console I/O bridge.
interface bf_io_bridge_if #(
    parameter int unsigned CPU_W  = 16,
    parameter int unsigned DATA_W = 8
);
    logic              cpu_ir;
    logic              cpu_ow;
    logic [CPU_W-1:0]  cpu_outpd;
    logic [CPU_W-1:0]  cpu_inpd;
    logic              cpu_stall;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_eof;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  cpu_ir, cpu_ow, cpu_outpd, in_data, in_valid, in_eof, out_ready,
        output cpu_inpd, cpu_stall, in_ready, out_data, out_valid
    );

    modport master (
        output cpu_ir, cpu_ow, cpu_outpd, in_data, in_valid, in_eof, out_ready,
        input  cpu_inpd, cpu_stall, in_ready, out_data, out_valid
    );
endinterface

// File: rtl/bf_sync_fifo.sv
// Synchronous FIFO; full/empty derive from an occupancy count so all entries are usable.
module bf_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [LW-1:0]    cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign dout    = mem[rp];
    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/bf_io_bridge.sv
// Buffered BFCPU console bridge: toggle-style IR/OW pins to byte streams with FIFOs.
// Optional BF_IO_STATS_EN adds saturating read/write/stall counters.
module bf_io_bridge
    import bf_io_pkg::*;
#(
    parameter int unsigned      CPU_W     = 16,
    parameter int unsigned      DATA_W    = 8,
    parameter int unsigned      IN_DEPTH  = 16,
    parameter int unsigned      OUT_DEPTH = 16,
    parameter logic [CPU_W-1:0] EOF_VALUE = {CPU_W{EOF_BIT}}
) (
    input  logic                          clk,
    input  logic                          reset,
    bf_io_bridge_if.slave                 io,
    output logic [lvl_w(IN_DEPTH)-1:0]    in_level,
    output logic [lvl_w(OUT_DEPTH)-1:0]   out_level
`ifdef BF_IO_STATS_EN
    ,
    output logic [STAT_W-1:0]             stat_rd,
    output logic [STAT_W-1:0]             stat_wr,
    output logic [STAT_W-1:0]             stat_stall
`endif
);
    logic              ir_q, ow_q;
    logic              rd_pend, wr_pend;
    logic              in_full, in_empty, out_full, out_empty;
    logic              in_push, in_pop, out_push, out_pop;
    logic [DATA_W-1:0] in_head;
    logic [CPU_W-1:0]  inpd_q;
    rd_act_e           rd_act;

    assign rd_pend      = (io.cpu_ir != ir_q);
    assign wr_pend      = (io.cpu_ow != ow_q);
    assign io.in_ready  = !in_full;
    assign io.out_valid = !out_empty;
    assign in_push      = io.in_valid && !in_full;
    assign out_pop      = !out_empty && io.out_ready;
    assign in_pop       = (rd_act == RD_DATA);
    assign out_push     = wr_pend && !out_full;
    assign io.cpu_stall = (rd_act == RD_WAIT) || (wr_pend && out_full);
    assign io.cpu_inpd  = inpd_q;

    bf_sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_push),
        .din   (io.in_data),
        .pop   (in_pop),
        .dout  (in_head),
        .full  (in_full),
        .empty (in_empty),
        .level (in_level)
    );

    bf_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out_push),
        .din   (io.cpu_outpd[DATA_W-1:0]),
        .pop   (out_pop),
        .dout  (io.out_data),
        .full  (out_full),
        .empty (out_empty),
        .level (out_level)
    );

    always_comb begin
        rd_act = RD_NONE;
        if (rd_pend) begin
            if (!in_empty)      rd_act = RD_DATA;
            else if (io.in_eof) rd_act = RD_EOF;
            else                rd_act = RD_WAIT;
        end
    end

    // Reset captures the current pin levels so no request is seen afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q   <= io.cpu_ir;
            ow_q   <= io.cpu_ow;
            inpd_q <= '0;
        end else begin
            case (rd_act)
                RD_DATA: begin
                    inpd_q <= CPU_W'(in_head);
                    ir_q   <= io.cpu_ir;
                end
                RD_EOF: begin
                    inpd_q <= EOF_VALUE;
                    ir_q   <= io.cpu_ir;
                end
                default: ;
            endcase
            if (out_push) ow_q <= io.cpu_ow;
        end
    end

`ifdef BF_IO_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rd    <= '0;
            stat_wr    <= '0;
            stat_stall <= '0;
        end else begin
            if ((rd_act == RD_DATA || rd_act == RD_EOF) && stat_rd != '1) stat_rd <= stat_rd + 1'b1;
            if (out_push && stat_wr != '1)                                 stat_wr <= stat_wr + 1'b1;
            if (io.cpu_stall && stat_stall != '1)                          stat_stall <= stat_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_bf_io_bridge.sv
// Scoreboard bench for bf_io_bridge: directed scenarios followed by randomized traffic.
module tb_bf_io_bridge;
    import bf_io_pkg::*;

    localparam int unsigned CPU_W     = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned IN_DEPTH  = 16;
    localparam int unsigned OUT_DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bf_io_bridge_if #(.CPU_W(CPU_W), .DATA_W(DATA_W)) io ();
    logic [4:0] in_level, out_level;
`ifdef BF_IO_STATS_EN
    logic [31:0] stat_rd, stat_wr, stat_stall;
`endif

    bf_io_bridge #(
        .CPU_W     (CPU_W),
        .DATA_W    (DATA_W),
        .IN_DEPTH  (IN_DEPTH),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .io        (io),
        .in_level  (in_level),
        .out_level (out_level)
`ifdef BF_IO_STATS_EN
        ,
        .stat_rd    (stat_rd),
        .stat_wr    (stat_wr),
        .stat_stall (stat_stall)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_rd[$];
    logic [7:0]  exp_out[$];
    bit rd_out = 1'b0;
    bit wr_out = 1'b0;
    bit rd_svc = 1'b0;
    bit cpu_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name, input string why);
        total++;
        bad++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Monitor: records accepted input bytes and checks every CPU read and stream output.
    always @(negedge clk) begin
        if (reset) begin
            rd_svc = 1'b0;
        end else begin
            if (io.in_valid && io.in_ready) exp_rd.push_back(16'(io.in_data));
            if (io.out_valid && io.out_ready) begin
                if (exp_out.size() == 0) fail_msg("out_data", $sformatf("got %h, none expected", io.out_data));
                else chk("out_data", 32'(io.out_data), 32'(exp_out.pop_front()));
            end
            if (rd_svc) begin
                if (exp_rd.size() == 0) fail_msg("cpu_inpd", $sformatf("got %h, none expected", io.cpu_inpd));
                else chk("cpu_inpd", 32'(io.cpu_inpd), 32'(exp_rd.pop_front()));
                rd_out = 1'b0;
                rd_svc = 1'b0;
            end else if (rd_out && !io.cpu_stall) begin
                rd_svc = 1'b1;
            end
            if (wr_out && !io.cpu_stall) wr_out = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [15:0] wv);
        if (wr) begin
            io.cpu_outpd = wv;
            io.cpu_ow    = ~io.cpu_ow;
            exp_out.push_back(wv[7:0]);
            wr_out = 1'b1;
        end
        if (rd) begin
            io.cpu_ir = ~io.cpu_ir;
            rd_out = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((rd_out || wr_out) && n < 400) begin
            step();
            n++;
        end
        if (rd_out || wr_out) begin
            fail_msg(name, $sformatf("request not serviced, rd_out=%0d wr_out=%0d", rd_out, wr_out));
            rd_out = 1'b0;
            wr_out = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (io.out_valid && n < 400) begin
            step();
            n++;
        end
        chk(name, 32'(out_level), 32'd0);
    endtask

    task automatic stream_push(input logic [7:0] b);
        io.in_valid = 1'b1;
        io.in_data  = b;
        step();
        io.in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        io.cpu_ir    = 1'b0;
        io.cpu_ow    = 1'b0;
        io.cpu_outpd = '0;
        io.in_data   = '0;
        io.in_valid  = 1'b0;
        io.in_eof    = 1'b0;
        io.out_ready = 1'b0;
        repeat (3) step();
        chk("rst_in_level", 32'(in_level), 32'd0);
        chk("rst_out_level", 32'(out_level), 32'd0);
        chk("rst_inpd", 32'(io.cpu_inpd), 32'd0);
        chk("rst_stall", 32'(io.cpu_stall), 32'd0);
        chk("rst_in_ready", 32'(io.in_ready), 32'd1);
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        reset = 1'b0;
        step();

        // Two buffered bytes, two reads.
        stream_push(8'h41);
        stream_push(8'h42);
        chk("t1_level2", 32'(in_level), 32'd2);
        issue(1'b1, 1'b0, '0);
        @(negedge clk);
        chk("t1_nostall", 32'(io.cpu_stall), 32'd0);
        wait_idle("t1_rd0");
        chk("t1_level1", 32'(in_level), 32'd1);
        issue(1'b1, 1'b0, '0);
        wait_idle("t1_rd1");
        chk("t1_level0", 32'(in_level), 32'd0);

        // Read on empty input stalls until a byte arrives.
        issue(1'b1, 1'b0, '0);
        @(negedge clk);
        chk("t2_stall", 32'(io.cpu_stall), 32'd1);
        step();
        step();
        stream_push(8'h7A);
        chk("t2_stall_drop", 32'(io.cpu_stall), 32'd0);
        wait_idle("t2_rd");
        chk("t2_level0", 32'(in_level), 32'd0);

        // End of input returns the EOF value without stalling.
        io.in_eof = 1'b1;
        exp_rd.push_back(16'hFFFF);
        issue(1'b1, 1'b0, '0);
        @(negedge clk);
        chk("t3_nostall", 32'(io.cpu_stall), 32'd0);
        wait_idle("t3_rd");
        io.in_eof = 1'b0;

        // Fill the output FIFO, then one more write stalls until the sink drains.
        io.out_ready = 1'b0;
        for (int i = 0; i < OUT_DEPTH; i++) begin
            issue(1'b0, 1'b1, 16'h1234 + 16'(i));
            wait_idle("t4_wr");
        end
        chk("t4_full_level", 32'(out_level), 32'(OUT_DEPTH));
        issue(1'b0, 1'b1, 16'h1234 + 16'(OUT_DEPTH));
        repeat (3) step();
        chk("t4_full_stall", 32'(io.cpu_stall), 32'd1);
        chk("t4_full_hold", 32'(out_level), 32'(OUT_DEPTH));
        chk("t4_head_hold", 32'(io.out_data), 32'h34);
        io.out_ready = 1'b1;
        wait_idle("t4_wr_last");
        wait_drain("t4_drain");
        chk("t4_exp_empty", 32'(exp_out.size()), 32'd0);

        // Simultaneous read and write are both serviced in one cycle.
        io.out_ready = 1'b0;
        stream_push(8'h55);
        issue(1'b1, 1'b1, 16'hAB66);
        @(negedge clk);
        chk("t5_nostall", 32'(io.cpu_stall), 32'd0);
        step();
        chk("t5_in_level", 32'(in_level), 32'd0);
        chk("t5_out_level", 32'(out_level), 32'd1);
        wait_idle("t5_rdwr");
        io.out_ready = 1'b1;
        wait_drain("t5_drain");

        // Reset with buffered bytes and pending requests.
        io.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) stream_push(8'($urandom));
        chk("t6_level5", 32'(in_level), 32'd5);
        reset        = 1'b1;
        io.cpu_ir    = ~io.cpu_ir;
        io.cpu_ow    = ~io.cpu_ow;
        io.cpu_outpd = 16'h00EE;
        step();
        step();
        chk("t6_rst_in_level", 32'(in_level), 32'd0);
        chk("t6_rst_inpd", 32'(io.cpu_inpd), 32'd0);
        chk("t6_rst_stall", 32'(io.cpu_stall), 32'd0);
`ifdef BF_IO_STATS_EN
        chk("t6_stat_rd", stat_rd, 32'd0);
        chk("t6_stat_wr", stat_wr, 32'd0);
        chk("t6_stat_stall", stat_stall, 32'd0);
`endif
        exp_rd.delete();
        exp_out.delete();
        reset = 1'b0;
        repeat (4) step();
        chk("t6_post_stall", 32'(io.cpu_stall), 32'd0);
        chk("t6_post_in_level", 32'(in_level), 32'd0);
        chk("t6_post_out_level", 32'(out_level), 32'd0);
        chk("t6_post_inpd", 32'(io.cpu_inpd), 32'd0);

        // Randomized traffic against the queue model.
        fork
            begin
                for (int c = 0; c < 20000 && !cpu_done; c++) begin
                    io.in_valid  = 1'($urandom % 2);
                    io.in_data   = 8'($urandom);
                    io.out_ready = (($urandom % 4) != 0);
                    step();
                end
                io.in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 300; k++) begin
                    int unsigned sel;
                    sel = $urandom % 3;
                    issue(sel != 1, sel != 0, 16'($urandom));
                    wait_idle("rnd_req");
                    if ($urandom % 2) step();
                end
                cpu_done = 1'b1;
            end
        join
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        step();
        step();
        wait_drain("rnd_drain");
        chk("rnd_out_exp_empty", 32'(exp_out.size()), 32'd0);
        chk("rnd_in_level", 32'(in_level), 32'(exp_rd.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
